// File: rtl/rvfi_trace_pkg.sv
// Shared constants, record type and FSM encodings for the RVFI trace UART.
// RVFI_TRACE_PC_WDATA_EN selects the extended record (pc_wdata appended, 14 bytes).
package rvfi_trace_pkg;

  localparam logic [7:0] TRACE_SYNC_BYTE = 8'hA5;

  localparam int unsigned FLAG_TRAP      = 0;
  localparam int unsigned FLAG_HALT      = 1;
  localparam int unsigned FLAG_INTR      = 2;
  localparam int unsigned FLAG_ORDER_GAP = 3;
  localparam int unsigned FLAG_DROPPED   = 4;
  localparam int unsigned FLAG_EXTENDED  = 5;

  localparam int unsigned REC_W_BASE     = 72;
  localparam int unsigned REC_W_EXT      = 104;
  localparam int unsigned REC_BYTES_BASE = 10;
  localparam int unsigned REC_BYTES_EXT  = 14;
  localparam int unsigned REC_IDX_W      = 4;

`ifdef RVFI_TRACE_PC_WDATA_EN
  localparam int unsigned REC_W        = REC_W_EXT;
  localparam int unsigned REC_BYTES    = REC_BYTES_EXT;
  localparam logic        REC_EXTENDED = 1'b1;

  typedef struct packed {
    logic [7:0]  flags;
    logic [31:0] pc_rdata;
    logic [31:0] insn;
    logic [31:0] pc_wdata;
  } rec_t;
`else
  localparam int unsigned REC_W        = REC_W_BASE;
  localparam int unsigned REC_BYTES    = REC_BYTES_BASE;
  localparam logic        REC_EXTENDED = 1'b0;

  typedef struct packed {
    logic [7:0]  flags;
    logic [31:0] pc_rdata;
    logic [31:0] insn;
  } rec_t;
`endif

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_LOAD,
    TX_SEND
  } tx_state_e;

  typedef enum logic {
    UART_IDLE,
    UART_BUSY
  } uart_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 UART byte transmitter, LSB first; accepts one byte per valid/ready handshake.
// The start bit appears on the cycle after accept; every bit lasts CLKS_PER_BIT cycles.
module uart_tx_byte
  import rvfi_trace_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       txd_o
);

  localparam int unsigned   CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    BIT_LAST = 4'd9;

  uart_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [8:0]    shift_q, shift_d;
  logic          txd_q, txd_d;

  assign ready_o = (state_q == UART_IDLE);
  assign txd_o   = txd_q;

  // shift_q holds the data bits with the stop bit on top; one bit moves to txd per bit period
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    unique case (state_q)
      UART_IDLE: begin
        if (valid_i) begin
          state_d = UART_BUSY;
          cnt_d   = '0;
          bit_d   = '0;
          shift_d = {1'b1, data_i};
          txd_d   = 1'b0;
        end
      end
      UART_BUSY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = UART_IDLE;
          end else begin
            bit_d   = bit_q + 4'd1;
            txd_d   = shift_q[0];
            shift_d = {1'b1, shift_q[8:1]};
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = UART_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= UART_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '1;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

endmodule

// File: rtl/rvfi_trace_uart.sv
// RVFI retirement trace sink: records into a FIFO, streamed as framed bytes over UART 8N1.
// RVFI_TRACE_PC_WDATA_EN appends pc_wdata to each record; otherwise rvfi_pc_wdata is unused.
module rvfi_trace_uart
  import rvfi_trace_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                        sys_clock,
  input  logic                        reset,
  input  logic                        rvfi_valid,
  input  logic [63:0]                 rvfi_order,
  input  logic [31:0]                 rvfi_insn,
  input  logic                        rvfi_trap,
  input  logic                        rvfi_halt,
  input  logic                        rvfi_intr,
  input  logic [31:0]                 rvfi_pc_rdata,
  input  logic [31:0]                 rvfi_pc_wdata,
  output logic                        trace_txd,
  output logic [15:0]                 drop_count,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned          AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned          LW       = AW + 1;
  localparam logic [LW-1:0]        LVL_FULL = LW'(FIFO_DEPTH);
  localparam logic [REC_IDX_W-1:0] IDX_LAST = REC_IDX_W'(REC_BYTES - 1);

  rec_t                 mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]        level_q, level_d;
  logic                 push, drop, pop;
  rec_t                 rec_in;
  logic [63:0]          last_order_q;
  logic                 order_seen_q;
  logic                 drop_pending_q, drop_pending_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;
  tx_state_e            state_q, state_d;
  rec_t                 rec_q;
  logic [REC_IDX_W-1:0] idx_q, idx_d;
  logic [7:0]           frame_b [REC_BYTES];
  logic                 tx_valid, tx_ready;

  assign fifo_level = level_q;
  assign drop_count = drop_cnt_q;

  always_comb begin
    rec_in                        = '0;
    rec_in.flags[FLAG_TRAP]       = rvfi_trap;
    rec_in.flags[FLAG_HALT]       = rvfi_halt;
    rec_in.flags[FLAG_INTR]       = rvfi_intr;
    rec_in.flags[FLAG_ORDER_GAP]  = order_seen_q && (rvfi_order != last_order_q + 64'd1);
    rec_in.flags[FLAG_DROPPED]    = drop_pending_q;
    rec_in.flags[FLAG_EXTENDED]   = REC_EXTENDED;
    rec_in.pc_rdata               = rvfi_pc_rdata;
    rec_in.insn                   = rvfi_insn;
`ifdef RVFI_TRACE_PC_WDATA_EN
    rec_in.pc_wdata               = rvfi_pc_wdata;
`endif
  end

`ifndef RVFI_TRACE_PC_WDATA_EN
  logic unused_pc_wdata;
  assign unused_pc_wdata = ^rvfi_pc_wdata;
`endif

  // Full is judged on the registered level, so a pop in the same cycle never makes room
  assign push = rvfi_valid && (level_q < LVL_FULL);
  assign drop = rvfi_valid && !push;

  always_comb begin
    drop_pending_d = drop_pending_q;
    if (drop)      drop_pending_d = 1'b1;
    else if (push) drop_pending_d = 1'b0;
    drop_cnt_d = (drop && (drop_cnt_q != '1)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    level_d    = level_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge sys_clock) begin
    if (push) mem_q[wr_ptr_q] <= rec_in;
  end

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      last_order_q   <= '0;
      order_seen_q   <= 1'b0;
      drop_pending_q <= 1'b0;
      drop_cnt_q     <= '0;
      rec_q          <= '0;
      idx_q          <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        rec_q    <= mem_q[rd_ptr_q];
      end
      if (rvfi_valid) begin
        last_order_q <= rvfi_order;
        order_seen_q <= 1'b1;
      end
      level_q        <= level_d;
      drop_pending_q <= drop_pending_d;
      drop_cnt_q     <= drop_cnt_d;
      idx_q          <= idx_d;
    end
  end

  always_ff @(posedge sys_clock or negedge reset) begin
    if (!reset) state_q <= TX_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TX_IDLE: if (level_q != '0) state_d = TX_LOAD;
      TX_LOAD: state_d = TX_SEND;
      TX_SEND: if (tx_ready && (idx_q == IDX_LAST)) state_d = TX_IDLE;
      default: state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    pop      = (state_q == TX_IDLE) && (level_q != '0);
    tx_valid = (state_q == TX_SEND);
    idx_d    = idx_q;
    if (state_q == TX_LOAD) idx_d = '0;
    else if (tx_valid && tx_ready && (idx_q != IDX_LAST)) idx_d = idx_q + REC_IDX_W'(1);
  end

  always_comb begin
    frame_b[0] = TRACE_SYNC_BYTE;
    frame_b[1] = rec_q.flags;
    frame_b[2] = rec_q.pc_rdata[31:24];
    frame_b[3] = rec_q.pc_rdata[23:16];
    frame_b[4] = rec_q.pc_rdata[15:8];
    frame_b[5] = rec_q.pc_rdata[7:0];
    frame_b[6] = rec_q.insn[31:24];
    frame_b[7] = rec_q.insn[23:16];
    frame_b[8] = rec_q.insn[15:8];
    frame_b[9] = rec_q.insn[7:0];
`ifdef RVFI_TRACE_PC_WDATA_EN
    frame_b[10] = rec_q.pc_wdata[31:24];
    frame_b[11] = rec_q.pc_wdata[23:16];
    frame_b[12] = rec_q.pc_wdata[15:8];
    frame_b[13] = rec_q.pc_wdata[7:0];
`endif
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk_i  (sys_clock),
    .rst_ni (reset),
    .data_i (frame_b[idx_q]),
    .valid_i(tx_valid),
    .ready_o(tx_ready),
    .txd_o  (trace_txd)
  );

endmodule

// File: tb/tb_rvfi_trace_uart.sv
// Scoreboard bench for rvfi_trace_uart: a record-level model queues expected bytes,
// a UART receiver monitor checks bit timing and compares each received byte.
module tb_rvfi_trace_uart;

  localparam int unsigned CPB   = 5;
  localparam int unsigned DEPTH = 16;
  localparam int          LIMIT = 30000;
`ifdef RVFI_TRACE_PC_WDATA_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rvfi_valid = 1'b0;
  logic [63:0] rvfi_order = '0;
  logic [31:0] rvfi_insn = '0;
  logic        rvfi_trap = 1'b0;
  logic        rvfi_halt = 1'b0;
  logic        rvfi_intr = 1'b0;
  logic [31:0] rvfi_pc_rdata = '0;
  logic [31:0] rvfi_pc_wdata = '0;
  logic        trace_txd;
  logic [15:0] drop_count;
  logic [4:0]  fifo_level;

  always #5 clk = ~clk;

  rvfi_trace_uart #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .sys_clock    (clk),
    .reset        (rst_n),
    .rvfi_valid   (rvfi_valid),
    .rvfi_order   (rvfi_order),
    .rvfi_insn    (rvfi_insn),
    .rvfi_trap    (rvfi_trap),
    .rvfi_halt    (rvfi_halt),
    .rvfi_intr    (rvfi_intr),
    .rvfi_pc_rdata(rvfi_pc_rdata),
    .rvfi_pc_wdata(rvfi_pc_wdata),
    .trace_txd    (trace_txd),
    .drop_count   (drop_count),
    .fifo_level   (fifo_level)
  );

  int         checks = 0;
  int         errors = 0;
  int         mon_bytes = 0;
  logic [7:0] exp_q [$];

  // Reference model state, kept at record level
  logic [63:0] m_last = '0;
  bit          m_seen = 1'b0;
  bit          m_pend = 1'b0;
  int          m_drops = 0;
  int          m_occ = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_last = '0;
    m_seen = 1'b0;
    m_pend = 1'b0;
    m_drops = 0;
    m_occ = 0;
    exp_q.delete();
  endtask

  task automatic push32(input logic [31:0] w);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  // Drives one retirement for the coming posedge; call and return at a negedge
  task automatic retire(input logic [63:0] order, input logic [31:0] pc, input logic [31:0] insn,
                        input logic [31:0] wpc, input bit trap, input bit halt, input bit intr);
    logic [7:0] fl;
    rvfi_valid = 1'b1;
    rvfi_order = order;
    rvfi_pc_rdata = pc;
    rvfi_insn = insn;
    rvfi_pc_wdata = wpc;
    rvfi_trap = trap;
    rvfi_halt = halt;
    rvfi_intr = intr;
    if (m_occ < DEPTH) begin
      fl = {2'b00, EXT, m_pend, (m_seen && (order != m_last + 64'd1)), intr, halt, trap};
      exp_q.push_back(8'hA5);
      exp_q.push_back(fl);
      push32(pc);
      push32(insn);
      if (EXT) push32(wpc);
      m_pend = 1'b0;
      m_occ++;
    end else begin
      if (m_drops < 65535) m_drops++;
      m_pend = 1'b1;
    end
    m_last = order;
    m_seen = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    rvfi_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    rvfi_valid = 1'b0;
    while (exp_q.size() != 0 && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    check(name, exp_q.size(), 0);
    repeat (2 * CPB) @(negedge clk);
    m_occ = 0;
  endtask

  // UART receiver: every bit is sampled on all CPB cycles of its period
  initial begin : monitor
    logic [9:0] lvl;
    bit         ok;
    bit         abort;
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (rst_n && !trace_txd) begin
        ok = 1'b1;
        abort = 1'b0;
        lvl = '0;
        for (int b = 0; b < 10 && !abort; b++) begin
          for (int c = 0; c < int'(CPB) && !abort; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (!rst_n) abort = 1'b1;
            else if (c == 0) lvl[b] = trace_txd;
            else if (trace_txd !== lvl[b]) ok = 1'b0;
          end
        end
        if (!abort) begin
          check("frame", {ok, lvl[0], lvl[9]}, 3'b101);
          if (exp_q.size() == 0) begin
            check("unexpected_byte", lvl[8:1], 9'h100);
          end else begin
            exp = exp_q.pop_front();
            check("byte", lvl[8:1], exp);
          end
          mon_bytes++;
        end
      end
    end
  end

  initial begin : stimulus
    int          lat;
    int          t;
    int          base;
    int          n;
    logic [63:0] ord;
    repeat (3) @(negedge clk);
    check("reset_txd", trace_txd, 1);
    check("reset_level", fifo_level, 0);
    check("reset_drops", drop_count, 0);
    rst_n = 1'b1;
    idle(3);

    // Single record and push-to-start latency
    retire(64'd0, 32'h8000_0000, 32'h0000_0013, 32'h8000_0004, 0, 0, 0);
    rvfi_valid = 1'b0;
    lat = 0;
    for (int i = 1; i <= 4; i++) begin
      if (!trace_txd && lat == 0) lat = i;
      if (i < 4) @(negedge clk);
    end
    check("latency", lat != 0, 1);
    drain("drain_single");
    check("idle_high", trace_txd, 1);

    retire(64'd1, 32'h0000_1000, 32'h0000_0073, 32'h0000_1004, 1, 0, 1);
    retire(64'd2, 32'h0000_1004, 32'h1050_0073, 32'h0000_1004, 0, 1, 0);
    drain("drain_flags");

    // Overflow: TX busy with a priming record, then 20 back-to-back retirements
    retire(64'd1000, 32'hDEAD_BEEC, 32'h0000_0013, 32'hDEAD_BEF0, 0, 0, 0);
    idle(3);
    m_occ = 0;
    for (int i = 0; i < 20; i++)
      retire(64'(i), 32'h0000_2000 + 32'(4 * i), $urandom, $urandom, 0, 0, 0);
    rvfi_valid = 1'b0;
    check("full_level", fifo_level, DEPTH);
    check("drops_after_burst", drop_count, 64'(m_drops));
    drain("drain_burst");
    retire(64'd20, 32'h0000_3000, 32'h0000_0013, 32'h0000_3004, 0, 0, 0);
    retire(64'd21, 32'h0000_3004, 32'h0000_0013, 32'h0000_3008, 0, 0, 0);
    drain("drain_after_drop");
    check("drops_held", drop_count, 64'(m_drops));

    // Order wrap, then randomized bursts kept below FIFO capacity
    retire(64'hFFFF_FFFF_FFFF_FFFE, 32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 0, 0, 0);
    retire(64'hFFFF_FFFF_FFFF_FFFF, 32'h1111_2226, 32'h3333_4448, 32'h5555_666A, 0, 0, 0);
    retire(64'd0, 32'h1111_222A, 32'h3333_444C, 32'h5555_666E, 0, 0, 0);
    drain("drain_wrap");
    ord = 64'd0;
    for (int b = 0; b < 5; b++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        ord = ($urandom_range(0, 3) == 0) ? {32'($urandom), 32'($urandom)} : ord + 64'd1;
        retire(ord, $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
        idle($urandom_range(0, 2));
      end
      drain("drain_random");
    end

    // Reset in the middle of a data bit of byte 3 (pc_rdata[23:16] = 0x00 keeps the line low)
    base = mon_bytes;
    retire(64'd77, 32'h1200_5678, 32'h0000_0013, 32'h1200_567C, 0, 0, 0);
    rvfi_valid = 1'b0;
    t = 0;
    while (mon_bytes < base + 3 && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    while (trace_txd && t < LIMIT) begin
      @(negedge clk);
      t++;
    end
    check("reach_byte3", t < LIMIT, 1);
    repeat (3 * CPB + CPB / 2) @(negedge clk);
    check("pre_reset_low", trace_txd, 0);
    rst_n = 1'b0;
    #1;
    check("midframe_txd", trace_txd, 1);
    check("midframe_level", fifo_level, 0);
    check("midframe_drops", drop_count, 0);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    retire(64'd5, 32'h8000_0100, 32'h0010_0093, 32'h8000_0104, 0, 0, 0);
    retire(64'd6, 32'h8000_0104, 32'h0020_0113, 32'h8000_0108, 0, 0, 0);
    retire(64'd8, 32'h8000_010C, 32'h0030_0193, 32'h8000_0110, 0, 0, 0);
    drain("drain_after_reset");

    check("final_txd", trace_txd, 1);
    check("final_level", fifo_level, 0);
    check("final_drops", drop_count, 64'(m_drops));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
